// File: rtl/timer_tick_pkg.sv
// Shared definitions for the interval-timer master: register map, bit
// positions, the control word written at start-up and the FSM state type.
package timer_tick_pkg;

    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd1;
    localparam logic [2:0] ADDR_PERIODL = 3'd2;
    localparam logic [2:0] ADDR_PERIODH = 3'd3;

    localparam int STAT_TO  = 0;
    localparam int STAT_RUN = 1;

    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    // Interrupt enable, continuous mode, start.
    localparam logic [15:0] CTRL_START_CONT_ITO = 16'h0007;

    typedef enum logic [2:0] {
        ST_INIT_PL,
        ST_INIT_PH,
        ST_INIT_CTRL,
        ST_IDLE,
        ST_RD_STAT,
        ST_RD_WAIT,
        ST_CLR
    } tick_state_e;

endpackage

// File: rtl/time_of_day_counter.sv
// 24-hour hh:mm:ss counter. A valid set request overrides a simultaneous
// advance; an out-of-range set request is dropped as a whole.
module time_of_day_counter
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       advance,
    input  logic       set_en,
    input  logic [4:0] set_hours,
    input  logic [5:0] set_minutes,
    input  logic [5:0] set_seconds,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds
);

    logic set_valid;

    // Accept a set only when all three fields are in range.
    always_comb begin
        set_valid = set_en && (set_hours <= 5'd23) &&
                    (set_minutes <= 6'd59) && (set_seconds <= 6'd59);
    end

    // Time registers: load has priority over the ripple-carry advance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hours   <= 5'd0;
            minutes <= 6'd0;
            seconds <= 6'd0;
        end else if (set_valid) begin
            hours   <= set_hours;
            minutes <= set_minutes;
            seconds <= set_seconds;
        end else if (advance) begin
            if (seconds == 6'd59) begin
                seconds <= 6'd0;
                if (minutes == 6'd59) begin
                    minutes <= 6'd0;
                    hours   <= (hours == 5'd23) ? 5'd0 : hours + 5'd1;
                end else begin
                    minutes <= minutes + 6'd1;
                end
            end else begin
                seconds <= seconds + 6'd1;
            end
        end
    end

endmodule

// File: rtl/timer_tick_master.sv
// Avalon-MM master for the interval timer: programs it after reset, then
// services each timeout interrupt and advances the time of day.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_INIT_PL   | issue PERIODL write next cycle
// ST_INIT_PH   | issue PERIODH write next cycle
// ST_INIT_CTRL | issue CONTROL write next cycle, then ready
// ST_IDLE      | bus quiet, waiting for timer_irq
// ST_RD_STAT   | STATUS read address on the bus
// ST_RD_WAIT   | STATUS data returned; decide fault / clear / spurious
// ST_CLR       | STATUS clear write on the bus; time advances
//
// Bus outputs are registered and loaded with the action of the cycle being
// entered, so the STATUS read is on the bus during ST_RD_STAT and its
// registered readdata is available in ST_RD_WAIT.
module timer_tick_master
    import timer_tick_pkg::*;
#(
    parameter logic [31:0] PERIOD = 32'd49_999_999
)
(
    input  logic        clk,
    input  logic        reset_n,
    output logic [2:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [15:0] avm_writedata,
    input  logic [15:0] avm_readdata,
    input  logic        timer_irq,
    input  logic        set_en,
    input  logic [4:0]  set_hours,
    input  logic [5:0]  set_minutes,
    input  logic [5:0]  set_seconds,
    output logic [4:0]  hours,
    output logic [5:0]  minutes,
    output logic [5:0]  seconds,
    output logic        sec_tick,
    output logic        ready,
    output logic        fault
);

    tick_state_e state, state_nxt;
    logic [2:0]  addr_nxt;
    logic        cs_nxt;
    logic        write_n_nxt;
    logic [15:0] wdata_nxt;
    logic        ready_nxt;
    logic        fault_nxt;
    logic        advance;

    // Next state plus the bus cycle and flags to present in the next cycle.
    always_comb begin
        state_nxt   = state;
        addr_nxt    = ADDR_STATUS;
        cs_nxt      = 1'b0;
        write_n_nxt = 1'b1;
        wdata_nxt   = 16'h0000;
        ready_nxt   = ready;
        fault_nxt   = fault;
        unique case (state)
            ST_INIT_PL: begin
                addr_nxt    = ADDR_PERIODL;
                cs_nxt      = 1'b1;
                write_n_nxt = 1'b0;
                wdata_nxt   = PERIOD[15:0];
                state_nxt   = ST_INIT_PH;
            end
            ST_INIT_PH: begin
                addr_nxt    = ADDR_PERIODH;
                cs_nxt      = 1'b1;
                write_n_nxt = 1'b0;
                wdata_nxt   = PERIOD[31:16];
                state_nxt   = ST_INIT_CTRL;
            end
            ST_INIT_CTRL: begin
                addr_nxt    = ADDR_CONTROL;
                cs_nxt      = 1'b1;
                write_n_nxt = 1'b0;
                wdata_nxt   = CTRL_START_CONT_ITO;
                ready_nxt   = 1'b1;
                state_nxt   = ST_IDLE;
            end
            ST_IDLE: begin
                if (timer_irq) begin
                    cs_nxt    = 1'b1;
                    state_nxt = ST_RD_STAT;
                end
            end
            ST_RD_STAT: begin
                state_nxt = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (!avm_readdata[STAT_RUN]) begin
                    fault_nxt = 1'b1;
                    ready_nxt = 1'b0;
                    state_nxt = ST_INIT_PL;
                end else if (avm_readdata[STAT_TO]) begin
                    addr_nxt    = ADDR_STATUS;
                    cs_nxt      = 1'b1;
                    write_n_nxt = 1'b0;
                    state_nxt   = ST_CLR;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_CLR: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_INIT_PL;
            end
        endcase
    end

    // State, bus and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_INIT_PL;
            avm_address    <= 3'd0;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_writedata  <= 16'h0000;
            ready          <= 1'b0;
            fault          <= 1'b0;
            sec_tick       <= 1'b0;
        end else begin
            state          <= state_nxt;
            avm_address    <= addr_nxt;
            avm_chipselect <= cs_nxt;
            avm_write_n    <= write_n_nxt;
            avm_writedata  <= wdata_nxt;
            ready          <= ready_nxt;
            fault          <= fault_nxt;
            sec_tick       <= (state == ST_CLR);
        end
    end

    assign advance = (state == ST_CLR);

    time_of_day_counter u_tod (
        .clk         (clk),
        .reset_n     (reset_n),
        .advance     (advance),
        .set_en      (set_en),
        .set_hours   (set_hours),
        .set_minutes (set_minutes),
        .set_seconds (set_seconds),
        .hours       (hours),
        .minutes     (minutes),
        .seconds     (seconds)
    );

endmodule

// File: tb/tb_timer_tick_master.sv
// Directed bench for timer_tick_master with a small behavioural interval
// timer behind the bus and an override path for forcing STATUS values.
module tb_timer_tick_master;

    localparam logic [31:0] PERIOD = 32'd99;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [15:0] avm_writedata;
    logic [15:0] avm_readdata;
    logic        timer_irq;
    logic        set_en = 1'b0;
    logic [4:0]  set_hours = 5'd0;
    logic [5:0]  set_minutes = 6'd0;
    logic [5:0]  set_seconds = 6'd0;
    logic [4:0]  hours;
    logic [5:0]  minutes;
    logic [5:0]  seconds;
    logic        sec_tick;
    logic        ready;
    logic        fault;

    int n_checks = 0;
    int n_pass   = 0;
    int n_ticks  = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    timer_tick_master #(.PERIOD(PERIOD)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .timer_irq      (timer_irq),
        .set_en         (set_en),
        .set_hours      (set_hours),
        .set_minutes    (set_minutes),
        .set_seconds    (set_seconds),
        .hours          (hours),
        .minutes        (minutes),
        .seconds        (seconds),
        .sec_tick       (sec_tick),
        .ready          (ready),
        .fault          (fault)
    );

    // Behavioural interval timer plus STATUS override.
    logic [15:0] tm_pl, tm_ph, tm_ctrl, tm_rd;
    logic        tm_to, tm_run;
    logic [31:0] tm_cnt;
    int          n_writes;
    logic        force_mode = 1'b0;
    logic        force_irq  = 1'b0;
    logic [15:0] force_status = 16'h0000;

    always_comb begin
        case (avm_address)
            3'd0:    tm_rd = {14'd0, tm_run, tm_to};
            3'd1:    tm_rd = tm_ctrl;
            3'd2:    tm_rd = tm_pl;
            3'd3:    tm_rd = tm_ph;
            default: tm_rd = 16'h0000;
        endcase
    end

    assign timer_irq = force_mode ? force_irq : (tm_to && tm_ctrl[0]);

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tm_pl <= 16'h0; tm_ph <= 16'h0; tm_ctrl <= 16'h0;
            tm_to <= 1'b0; tm_run <= 1'b0; tm_cnt <= 32'd0;
            avm_readdata <= 16'h0; n_writes <= 0;
        end else begin
            avm_readdata <= force_mode ? force_status : tm_rd;
            if (tm_run) begin
                if (tm_cnt == 32'd0) begin
                    tm_to  <= 1'b1;
                    tm_cnt <= {tm_ph, tm_pl};
                end else begin
                    tm_cnt <= tm_cnt - 32'd1;
                end
            end
            if (avm_chipselect && !avm_write_n) begin
                n_writes <= n_writes + 1;
                case (avm_address)
                    3'd0: tm_to <= 1'b0;
                    3'd1: begin
                        tm_ctrl <= avm_writedata;
                        if (avm_writedata[2]) begin
                            tm_run <= 1'b1;
                            tm_cnt <= {tm_ph, tm_pl};
                        end
                        if (avm_writedata[3]) tm_run <= 1'b0;
                    end
                    3'd2: tm_pl <= avm_writedata;
                    3'd3: tm_ph <= avm_writedata;
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (sec_tick) n_ticks <= n_ticks + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic do_set(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        set_en = 1'b1; set_hours = h; set_minutes = m; set_seconds = s;
        @(negedge clk);
        set_en = 1'b0;
    endtask

    task automatic wait_tick(input int max_cyc);
        for (int i = 0; i < max_cyc && !sec_tick; i++) @(negedge clk);
        check("tick_seen", sec_tick, 1);
    endtask

    task automatic check_write(input string tag, input logic [2:0] a, input logic [15:0] d);
        check({tag, "_cs"}, avm_chipselect, 1);
        check({tag, "_wn"}, avm_write_n, 0);
        check({tag, "_addr"}, avm_address, a);
        check({tag, "_data"}, avm_writedata, d);
    endtask

    task automatic check_time(input string tag, input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        check({tag, "_hh"}, hours, h);
        check({tag, "_mm"}, minutes, m);
        check({tag, "_ss"}, seconds, s);
    endtask

    initial begin
        int t0, w0, rel;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_addr", avm_address, 0);
        check("rst_cs", avm_chipselect, 0);
        check("rst_wn", avm_write_n, 1);
        check("rst_wd", avm_writedata, 0);
        check("rst_ready", ready, 0);
        check("rst_fault", fault, 0);
        check("rst_tick", sec_tick, 0);
        check_time("rst", 0, 0, 0);

        // Init sequence on the first three edges after release
        reset_n = 1'b1;
        rel = cyc;
        @(negedge clk); check_write("init_pl", 3'd2, 16'h0063);
        check("init_pl_ready", ready, 0);
        @(negedge clk); check_write("init_ph", 3'd3, 16'h0000);
        @(negedge clk); check_write("init_ctrl", 3'd1, 16'h0007);
        check("init_ready", ready, 1);
        @(negedge clk);
        check("post_init_cs", avm_chipselect, 0);

        // First timeout
        wait_tick(300);
        check("first_tick_window", ((cyc - rel) >= 100 && (cyc - rel) <= 115) ? 1 : 0, 1);
        check_time("first", 0, 0, 1);

        // Full wrap 23:59:59 -> 00:00:00
        do_set(5'd23, 6'd59, 6'd59);
        check_time("set_max", 23, 59, 59);
        t0 = n_ticks;
        wait_tick(300);
        check_time("wrap", 0, 0, 0);
        repeat (3) @(negedge clk);
        check("wrap_one_tick", n_ticks - t0, 1);
        check("timer_to_cleared", tm_to, 0);

        // Set coinciding with CLR wins over the advance
        do_set(5'd1, 6'd2, 6'd3);
        check_time("pre_clr", 1, 2, 3);
        for (int i = 0; i < 300 && !(avm_chipselect && !avm_write_n && avm_address == 3'd0); i++)
            @(negedge clk);
        check("clr_seen", {avm_chipselect, avm_write_n, avm_address}, {1'b1, 1'b0, 3'd0});
        do_set(5'd12, 6'd34, 6'd56);
        check_time("set_in_clr", 12, 34, 56);
        check("set_in_clr_tick", sec_tick, 1);
        @(negedge clk);
        check("tick_single", sec_tick, 0);

        // Out-of-range sets are dropped, valid set then loads
        do_set(5'd5, 6'd60, 6'd5);
        check_time("bad_min", 12, 34, 56);
        do_set(5'd24, 6'd0, 6'd0);
        check_time("bad_hr", 12, 34, 56);
        do_set(5'd7, 6'd8, 6'd9);
        check_time("good_set", 7, 8, 9);

        // Spurious interrupt: STATUS TO=0 RUN=1
        force_mode = 1'b1; force_status = 16'h0002;
        @(negedge clk);
        w0 = n_writes; t0 = n_ticks;
        force_irq = 1'b1;                          // cycle T
        @(negedge clk); force_irq = 1'b0;          // T+1
        check("sp_rd_cs", avm_chipselect, 1);
        check("sp_rd_wn", avm_write_n, 1);
        check("sp_rd_addr", avm_address, 0);
        @(negedge clk);                            // T+2
        check("sp_wait_cs", avm_chipselect, 0);
        @(negedge clk); force_irq = 1'b1;          // T+3, back in IDLE
        check("sp_t3_cs", avm_chipselect, 0);
        @(negedge clk); force_irq = 1'b0;          // T+4
        check("sp_reidle_rd", {avm_chipselect, avm_write_n}, 2'b11);
        repeat (4) @(negedge clk);
        check("sp_no_write", n_writes - w0, 0);
        check("sp_no_tick", n_ticks - t0, 0);
        check_time("sp_time", 7, 8, 9);

        // Stopped timer: STATUS RUN=0 -> fault and re-init
        force_status = 16'h0001;
        force_irq = 1'b1;                          // T
        @(negedge clk); force_irq = 1'b0;          // T+1
        check("flt_rd_cs", avm_chipselect, 1);
        @(negedge clk);                            // T+2
        @(negedge clk);                            // T+3
        check("flt_fault", fault, 1);
        check("flt_ready", ready, 0);
        check("flt_idle_cs", avm_chipselect, 0);
        @(negedge clk); check_write("reinit_pl", 3'd2, 16'h0063);
        @(negedge clk); check_write("reinit_ph", 3'd3, 16'h0000);
        @(negedge clk); check_write("reinit_ctrl", 3'd1, 16'h0007);
        check("reinit_ready", ready, 1);
        force_mode = 1'b0;
        wait_tick(300);
        check("flt_sticky", fault, 1);
        check_time("post_fault", 7, 8, 10);

        // Reset in the middle of a service aborts at once
        for (int i = 0; i < 300 && !(avm_chipselect && avm_write_n); i++) @(negedge clk);
        check("rd_before_rst", {avm_chipselect, avm_write_n}, 2'b11);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_cs", avm_chipselect, 0);
        check("mid_rst_wn", avm_write_n, 1);
        check("mid_rst_fault", fault, 0);
        check("mid_rst_ready", ready, 0);
        check_time("mid_rst", 0, 0, 0);
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk); check_write("rst_reinit_pl", 3'd2, 16'h0063);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/timer_tick_master.md
# timer_tick_master

Avalon-MM master that owns the interval timer peripheral on the clock board. Out of reset it programs the timer's period and control registers, then services every timer interrupt by reading status and clearing the timeout flag. It also maintains the 24-hour time-of-day counters that drive the display. It connects directly to the timer's 16-bit slave port, which has registered readdata and no waitrequest, and replaces CPU-side interrupt servicing for the clock path.

## Interface
Parameters:
- PERIOD, 32'd49_999_999, timer reload value; one timeout equals PERIOD+1 clocks (1 s at 50 MHz).

Ports:
- clk  in  1  system clock; the only clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- avm_address  out  3  timer register word address.
- avm_chipselect  out  1  slave select.
- avm_write_n  out  1  active-low write strobe.
- avm_writedata  out  16  write data.
- avm_readdata  in  16  timer read data, valid the cycle after the address is presented.
- timer_irq  in  1  timer interrupt, level-sensitive.
- set_en  in  1  one-cycle request to load the set_* values.
- set_hours  in  5  value to load, 0..23.
- set_minutes  in  6  value to load, 0..59.
- set_seconds  in  6  value to load, 0..59.
- hours  out  5  current hour.
- minutes  out  6  current minute.
- seconds  out  6  current second.
- sec_tick  out  1  one-cycle pulse per serviced timeout.
- ready  out  1  timer is programmed and running.
- fault  out  1  sticky flag: timer was found stopped; cleared only by reset.

## Operation
- Register map (word addresses): 0 STATUS (bit0 TO, bit1 RUN; any write clears TO), 1 CONTROL (bit0 ITO, bit1 CONT, bit2 START, bit3 STOP), 2 PERIODL, 3 PERIODH.
- FSM states and transitions:
  - INIT_PL: write PERIOD[15:0] to address 2, then go to INIT_PH.
  - INIT_PH: write PERIOD[31:16] to address 3, then go to INIT_CTRL.
  - INIT_CTRL: write 16'h0007 to address 1, then go to IDLE and set ready.
  - IDLE: no bus activity; go to RD_STAT if timer_irq is high.
  - RD_STAT: chipselect=1, write_n=1, address=0, then go to RD_WAIT.
  - RD_WAIT: sample avm_readdata.
    - If RUN=0: set fault, clear ready, go to INIT_PL.
    - Else if TO=1: go to CLR.
    - Else (spurious interrupt): go to IDLE.
  - CLR: write 16'h0000 to address 0, advance the time, go to IDLE.
- Each write is a single cycle with chipselect=1 and write_n=0. Outside write states, write_n=1, and chipselect=0 except in RD_STAT.
- Time advance: seconds wrap 59→0 and carry into minutes; minutes wrap 59→0 and carry into hours; hours wrap 23→0. All arithmetic is unsigned at port width.
- set_en is accepted in any state. It loads all three values only if every value is in range; otherwise the whole request is ignored.
- If set_en coincides with CLR, the set wins and the advance is discarded; sec_tick still pulses.
- While ready=0, set_en is still honoured.

## Timing
- Reset values:
  - Outputs: avm_address=0, avm_chipselect=0, avm_write_n=1, avm_writedata=0, hours/minutes/seconds=0, sec_tick=0, ready=0, fault=0.
  - FSM state: INIT_PL.
- Init writes land on the first three rising edges after reset_n deasserts. ready=1 from the 4th cycle onward.
- Service latency, with timer_irq seen high in IDLE in cycle T:
  - RD_STAT in T+1, RD_WAIT in T+2, CLR write in T+3.
  - New time and sec_tick=1 in T+4. Back in IDLE in T+4.
- The timer drops irq one cycle after the clear write, so IDLE in T+4 sees irq low. No double count occurs.
- Bus outputs are registered; no combinational path from avm_readdata to avm_* signals.
- Reset asserted mid-transaction aborts immediately. Bus returns to idle values and the init sequence restarts.

## Structure
- Package timer_tick_pkg holds:
  - register address constants (STATUS/CONTROL/PERIODL/PERIODH);
  - status and control bit indices;
  - CTRL_START_CONT_ITO = 16'h0007;
  - the FSM state enum.
- Sub-module time_of_day_counter: hh:mm:ss registers with an advance input, set input, range check, and wrap logic. The top module holds the FSM and bus registers.

## Test plan
- Reset release with PERIOD=99, connected to the real timer RTL -> writes addr2=16'h0063, addr3=16'h0000, addr1=16'h0007 on consecutive cycles; ready=1; first sec_tick about 100 cycles later; seconds=1.
- set 23:59:59, then one timeout -> exactly one sec_tick; time 00:00:00; timer TO bit reads 0 afterwards.
- Bus model drives irq with STATUS=16'h0002 (TO=0, RUN=1) -> no write, no sec_tick, return to IDLE in T+3.
- Bus model returns STATUS=16'h0001 (RUN=0) -> fault=1, ready=0, init write sequence re-issued; fault stays 1 afterwards.
- set_en=1 with 12:34:56 in the CLR cycle while the time is 01:02:03 -> time reads 12:34:56 with no increment; sec_tick pulses once.
- set_en with minutes=60 -> time unchanged; a following valid set_en loads normally.
